// File: rtl/uart_pkg.sv
// Shared UART-side definitions: arbiter FSM encoding, channel indices and default gap.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } arb_state_e;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int GAP_CYCLES_DEF = 16;

endpackage

// File: rtl/uart_tx_arbiter.sv
// Two-channel FIFO-to-uart_tx arbiter with start/busy handshake and inter-frame gap.
// Define TX_ARB_FIXED_PRIO_EN for strict ch0 priority instead of round-robin.
//
// state     | meaning
// IDLE      | waiting for a non-empty FIFO with the transmitter free; grant + pop here
// START     | tx_start pulse, tx_data already latched
// WAIT_ACK  | waiting for uart_tx to raise tx_busy
// WAIT_DONE | frame shifting; count the byte when tx_busy falls
// GAP       | enforced idle time before the next grant
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       fifo_empty,
  input  logic [WIDTH-1:0] fifo_data0,
  input  logic [WIDTH-1:0] fifo_data1,
  output logic [1:0]       fifo_rd_en,
  input  logic             tx_busy,
  output logic             tx_start,
  output logic [WIDTH-1:0] tx_data,
  output logic             grant_ch,
  output logic             active,
  output logic [CNT_W-1:0] sent_cnt0,
  output logic [CNT_W-1:0] sent_cnt1
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_e       state_q, state_d;
  logic             ready_q;
  logic [GW-1:0]    gap_q, gap_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             grant_ch_q, grant_ch_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic [1:0]       rd_en;
  logic             sel;
  logic             any_req;

  assign any_req = ~&fifo_empty;

`ifdef TX_ARB_FIXED_PRIO_EN
  assign sel = fifo_empty[CH0];
`else
  logic rr_q, rr_d;

  // rr_q is the last granted channel; a tie goes to the other one.
  assign sel = (fifo_empty == 2'b00) ? ~rr_q : fifo_empty[CH0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= CH1;
    else        rr_q <= rr_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    tx_data_d  = tx_data_q;
    grant_ch_d = grant_ch_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    rd_en      = 2'b00;
`ifndef TX_ARB_FIXED_PRIO_EN
    rr_d       = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // ready_q keeps the pop strobe low while reset is asserted.
        if (ready_q && !tx_busy && any_req) begin
          rd_en      = (sel == CH1) ? 2'b10 : 2'b01;
          tx_data_d  = (sel == CH1) ? fifo_data1 : fifo_data0;
          grant_ch_d = sel;
`ifndef TX_ARB_FIXED_PRIO_EN
          rr_d       = sel;
`endif
          state_d    = ST_START;
        end
      end
      ST_START:    state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (tx_busy) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          if (grant_ch_q == CH1) cnt1_d = cnt1_q + CNT_W'(1);
          else                   cnt0_d = cnt0_q + CNT_W'(1);
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      gap_q      <= '0;
      tx_data_q  <= '0;
      grant_ch_q <= CH0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= 1'b1;
      gap_q      <= gap_d;
      tx_data_q  <= tx_data_d;
      grant_ch_q <= grant_ch_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
    end
  end

  assign fifo_rd_en = rd_en;
  assign tx_start   = (state_q == ST_START);
  assign active     = (state_q != ST_IDLE);
  assign tx_data    = tx_data_q;
  assign grant_ch   = grant_ch_q;
  assign sent_cnt0  = cnt0_q;
  assign sent_cnt1  = cnt1_q;

endmodule
